// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared motor drive state encodings and default constants
package motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_RAMP_DOWN = 3'd2,
        ST_BRAKE     = 3'd3,
        ST_LOCKOUT   = 3'd4
    } state_t;

    localparam int FAULT_CNT_W      = 8;
    localparam int DEF_DUTY_W       = 4;
    localparam int DEF_RAMP_DIV     = 8;
    localparam int DEF_BRAKE_CYCLES = 50;

endpackage

// File: rtl/motor_shutdown_ctrl_pwm_gen.sv
// rtl/motor_shutdown_ctrl_pwm_gen.sv - free-running PWM counter and registered compare
module pwm_gen #(
    parameter int DUTY_W = 4
) (
    input  logic              clk_1khz,
    input  logic              rst,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_out
);

    // Last count value is 2^DUTY_W-2, so a full-scale duty compares high every cycle
    localparam logic [DUTY_W-1:0] CNT_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};

    logic [DUTY_W-1:0] r_cnt;
    logic              r_pwm;

    // Period counter, wraps after CNT_LAST
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered compare, gated by the drive enable
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= en & (r_cnt < duty);
        end
    end

    assign pwm_out = r_pwm;

endmodule

// File: rtl/motor_shutdown_ctrl.sv
// rtl/motor_shutdown_ctrl.sv - motor sequencer with watchdog safe stop and latched lockout
module motor_shutdown_ctrl
    import motor_pkg::*;
#(
    parameter int DUTY_W       = DEF_DUTY_W,
    parameter int RAMP_DIV     = DEF_RAMP_DIV,
    parameter int BRAKE_CYCLES = DEF_BRAKE_CYCLES
) (
    input  logic                   clk_1khz,
    input  logic                   rst,
    input  logic                   wd_fault,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   rearm,
    input  logic [DUTY_W-1:0]      duty_cmd,
    output logic                   pwm_out,
    output logic                   motor_en,
    output logic                   brake,
    output logic                   fault_latched,
    output logic [FAULT_CNT_W-1:0] fault_count,
    output logic [2:0]             state_o
);

    localparam int DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int BRAKE_W = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
    localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(RAMP_DIV - 1);
    localparam logic [BRAKE_W-1:0] BRAKE_MAX = BRAKE_W'(BRAKE_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DUTY_W-1:0]       r_duty_cur;
    logic [DUTY_W-1:0]       w_duty_nxt;
    logic [DIV_W-1:0]        r_div;
    logic [BRAKE_W-1:0]      r_brake_cnt;
    logic                    r_start_q;
    logic                    r_stop_q;
    logic                    r_rearm_q;
    logic                    r_fault_latched;
    logic [FAULT_CNT_W-1:0]  r_fault_count;
    logic                    r_motor_en;
    logic                    r_brake;
    logic [2:0]              r_state_o;
    logic                    w_start_pulse;
    logic                    w_stop_pulse;
    logic                    w_rearm_pulse;
    logic                    w_step;
    logic                    w_entry;
    logic                    w_fault_set;
    logic                    w_fault_inc;
    logic                    w_fault_clr;
    logic                    w_drive_en;

    assign w_start_pulse = start & ~r_start_q;
    assign w_stop_pulse  = stop  & ~r_stop_q;
    assign w_rearm_pulse = rearm & ~r_rearm_q;
    assign w_step        = (r_div == DIV_MAX);
    assign w_entry       = (w_state_nxt != r_state);
    assign w_drive_en    = (r_state == ST_RUN) || (r_state == ST_RAMP_DOWN);

    // Request edge detectors; cleared on reset so a level already high counts as a new request
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            r_start_q <= 1'b0;
            r_stop_q  <= 1'b0;
            r_rearm_q <= 1'b0;
        end else begin
            r_start_q <= start;
            r_stop_q  <= stop;
            r_rearm_q <= rearm;
        end
    end

    // State register
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, duty slew and fault bookkeeping; a watchdog fault outranks every request
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty_cur;
        w_fault_set = 1'b0;
        w_fault_inc = 1'b0;
        w_fault_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_pulse && !wd_fault && !w_stop_pulse) begin
                    w_state_nxt = ST_RUN;
                    w_duty_nxt  = '0;
                end
            end
            ST_RUN: begin
                if (wd_fault) begin
                    w_state_nxt = ST_BRAKE;
                    w_duty_nxt  = '0;
                    w_fault_set = 1'b1;
                    w_fault_inc = 1'b1;
                end else if (w_stop_pulse) begin
                    w_state_nxt = ST_RAMP_DOWN;
                end else if (w_step) begin
                    if (r_duty_cur < duty_cmd) begin
                        w_duty_nxt = r_duty_cur + 1'b1;
                    end else if (r_duty_cur > duty_cmd) begin
                        w_duty_nxt = r_duty_cur - 1'b1;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (wd_fault) begin
                    w_state_nxt = ST_BRAKE;
                    w_duty_nxt  = '0;
                    w_fault_set = 1'b1;
                    w_fault_inc = 1'b1;
                end else if (r_duty_cur == '0) begin
                    w_state_nxt = ST_BRAKE;
                end else if (w_step) begin
                    w_duty_nxt = r_duty_cur - 1'b1;
                    if (r_duty_cur == DUTY_W'(1)) begin
                        w_state_nxt = ST_BRAKE;
                    end
                end
            end
            ST_BRAKE: begin
                if (r_brake_cnt == BRAKE_MAX) begin
                    w_state_nxt = r_fault_latched ? ST_LOCKOUT : ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (w_rearm_pulse && !wd_fault) begin
                    w_state_nxt = ST_IDLE;
                    w_fault_clr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_BRAKE;
                w_duty_nxt  = '0;
                w_fault_set = 1'b1;
            end
        endcase
    end

    // Current duty, ramp divider and brake timer; both timers restart on any state change
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            r_duty_cur  <= '0;
            r_div       <= '0;
            r_brake_cnt <= '0;
        end else begin
            r_duty_cur <= w_duty_nxt;
            if (w_entry || w_step) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (w_entry) begin
                r_brake_cnt <= '0;
            end else if (r_state == ST_BRAKE && r_brake_cnt != BRAKE_MAX) begin
                r_brake_cnt <= r_brake_cnt + 1'b1;
            end
        end
    end

    // Fault latch and saturating fault-stop counter
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            r_fault_latched <= 1'b0;
            r_fault_count   <= '0;
        end else begin
            if (w_fault_set) begin
                r_fault_latched <= 1'b1;
            end else if (w_fault_clr) begin
                r_fault_latched <= 1'b0;
            end
            if (w_fault_inc && r_fault_count != {FAULT_CNT_W{1'b1}}) begin
                r_fault_count <= r_fault_count + 1'b1;
            end
        end
    end

    // Registered output decode; brake is the safe default for anything not driving
    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            r_motor_en <= 1'b0;
            r_brake    <= 1'b1;
            r_state_o  <= 3'd0;
        end else begin
            r_motor_en <= w_drive_en;
            r_brake    <= ~w_drive_en;
            r_state_o  <= r_state;
        end
    end

    pwm_gen #(
        .DUTY_W (DUTY_W)
    ) u_pwm_gen (
        .clk_1khz (clk_1khz),
        .rst      (rst),
        .en       (w_drive_en),
        .duty     (r_duty_cur),
        .pwm_out  (pwm_out)
    );

    assign motor_en      = r_motor_en;
    assign brake         = r_brake;
    assign state_o       = r_state_o;
    assign fault_latched = r_fault_latched;
    assign fault_count   = r_fault_count;

endmodule

// File: tb/tb_motor_shutdown_ctrl.sv
// tb/tb_motor_shutdown_ctrl.sv - directed bench for motor_shutdown_ctrl
module tb_motor_shutdown_ctrl;

    logic       clk_1khz = 1'b0;
    logic       rst;
    logic       wd_fault;
    logic       start;
    logic       stop;
    logic       rearm;
    logic [3:0] duty_cmd;
    logic       pwm_out;
    logic       motor_en;
    logic       brake;
    logic       fault_latched;
    logic [7:0] fault_count;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    int highs;

    motor_shutdown_ctrl dut (
        .clk_1khz      (clk_1khz),
        .rst           (rst),
        .wd_fault      (wd_fault),
        .start         (start),
        .stop          (stop),
        .rearm         (rearm),
        .duty_cmd      (duty_cmd),
        .pwm_out       (pwm_out),
        .motor_en      (motor_en),
        .brake         (brake),
        .fault_latched (fault_latched),
        .fault_count   (fault_count),
        .state_o       (state_o)
    );

    always #5 clk_1khz = ~clk_1khz;

    task automatic tick;
        @(posedge clk_1khz);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_pwm_window;
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (pwm_out === 1'b1) highs++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; wd_fault = 1'b0; start = 1'b0; stop = 1'b0; rearm = 1'b0; duty_cmd = 4'd15;
        tick_n(3);
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
        checks++; if (pwm_out !== 1'b0 || motor_en !== 1'b0 || brake !== 1'b1) begin errors++; $display("FAIL reset_outs got pwm=%b en=%b brk=%b exp 0 0 1", pwm_out, motor_en, brake); end
        checks++; if (fault_latched !== 1'b0 || fault_count !== 8'd0) begin errors++; $display("FAIL reset_fault got lat=%b cnt=%0d exp 0 0", fault_latched, fault_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_start_full_duty;
        start = 1'b1;
        tick();
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL start_lag got %0d exp 0", state_o); end
        start = 1'b0;
        tick();
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL start_run got %0d exp 1", state_o); end
        checks++; if (motor_en !== 1'b1 || brake !== 1'b0) begin errors++; $display("FAIL run_outs got en=%b brk=%b exp 1 0", motor_en, brake); end
        tick_n(125);
        count_pwm_window();
        checks++; if (highs !== 15) begin errors++; $display("FAIL full_duty_pwm got %0d highs exp 15", highs); end
    endtask

    task automatic test_stop_ramp;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        checks++; if (state_o !== 3'd2 || motor_en !== 1'b1) begin errors++; $display("FAIL ramp_enter got st=%0d en=%b exp 2 1", state_o, motor_en); end
        tick_n(119);
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL ramp_last got %0d exp 2", state_o); end
        tick();
        checks++; if (state_o !== 3'd3 || motor_en !== 1'b0 || brake !== 1'b1) begin errors++; $display("FAIL ramp_brake got st=%0d en=%b brk=%b exp 3 0 1", state_o, motor_en, brake); end
        tick_n(49);
        checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL brake_hold got %0d exp 3", state_o); end
        tick();
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL brake_idle got %0d exp 0", state_o); end
        checks++; if (fault_latched !== 1'b0 || fault_count !== 8'd0) begin errors++; $display("FAIL stop_nofault got lat=%b cnt=%0d exp 0 0", fault_latched, fault_count); end
    endtask

    task automatic test_fault_stop;
        duty_cmd = 4'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick_n(80);
        count_pwm_window();
        checks++; if (highs !== 8) begin errors++; $display("FAIL duty8_pwm got %0d highs exp 8", highs); end
        wd_fault = 1'b1;
        tick();
        checks++; if (fault_latched !== 1'b1 || fault_count !== 8'd1) begin errors++; $display("FAIL fault_set got lat=%b cnt=%0d exp 1 1", fault_latched, fault_count); end
        tick();
        checks++; if (state_o !== 3'd3 || motor_en !== 1'b0 || pwm_out !== 1'b0) begin errors++; $display("FAIL fault_brake got st=%0d en=%b pwm=%b exp 3 0 0", state_o, motor_en, pwm_out); end
        tick_n(49);
        checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL fault_brake_hold got %0d exp 3", state_o); end
        tick();
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL lockout got %0d exp 4", state_o); end
        checks++; if (fault_count !== 8'd1) begin errors++; $display("FAIL brake_no_recount got %0d exp 1", fault_count); end
    endtask

    task automatic test_lockout_rearm;
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        tick_n(2);
        checks++; if (state_o !== 3'd4 || fault_latched !== 1'b1) begin errors++; $display("FAIL rearm_in_fault got st=%0d lat=%b exp 4 1", state_o, fault_latched); end
        start = 1'b1;
        tick_n(2);
        start = 1'b0;
        tick();
        checks++; if (state_o !== 3'd4 || motor_en !== 1'b0) begin errors++; $display("FAIL start_in_lockout got st=%0d en=%b exp 4 0", state_o, motor_en); end
        wd_fault = 1'b0;
        tick();
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        checks++; if (fault_latched !== 1'b0) begin errors++; $display("FAIL rearm_clear got %b exp 0", fault_latched); end
        tick();
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL rearm_idle got %0d exp 0", state_o); end
    endtask

    task automatic test_simultaneous;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick_n(3);
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL sim_run got %0d exp 1", state_o); end
        stop = 1'b1;
        wd_fault = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (fault_count !== 8'd2 || fault_latched !== 1'b1) begin errors++; $display("FAIL fault_wins_cnt got cnt=%0d lat=%b exp 2 1", fault_count, fault_latched); end
        tick();
        checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL fault_wins_state got %0d exp 3", state_o); end
        tick_n(55);
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL sim_lockout got %0d exp 4", state_o); end
        wd_fault = 1'b0;
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        tick();
        start = 1'b1;
        stop = 1'b1;
        tick_n(3);
        checks++; if (state_o !== 3'd0 || motor_en !== 1'b0) begin errors++; $display("FAIL start_stop_idle got st=%0d en=%b exp 0 0", state_o, motor_en); end
        start = 1'b0;
        stop = 1'b0;
        tick();
    endtask

    task automatic do_fault_stop;
        start = 1'b1;
        tick();
        start = 1'b0;
        wd_fault = 1'b1;
        tick();
        tick_n(52);
        wd_fault = 1'b0;
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        tick();
    endtask

    task automatic test_saturation_and_reset;
        for (int i = 0; i < 253; i++) do_fault_stop();
        checks++; if (fault_count !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d exp 255", fault_count); end
        do_fault_stop();
        checks++; if (fault_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", fault_count); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL sat_idle got %0d exp 0", state_o); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick_n(80);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick_n(2);
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL pre_rst_ramp got %0d exp 2", state_o); end
        rst = 1'b1;
        tick();
        checks++; if (state_o !== 3'd0 || motor_en !== 1'b0 || brake !== 1'b1 || pwm_out !== 1'b0) begin errors++; $display("FAIL mid_rst_outs got st=%0d en=%b brk=%b pwm=%b exp 0 0 1 0", state_o, motor_en, brake, pwm_out); end
        checks++; if (fault_count !== 8'd0 || fault_latched !== 1'b0) begin errors++; $display("FAIL mid_rst_fault got cnt=%0d lat=%b exp 0 0", fault_count, fault_latched); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_start_full_duty();
        test_stop_ramp();
        test_fault_stop();
        test_lockout_rearm();
        test_simultaneous();
        test_saturation_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
